// File: rtl/arm_multicycle_controller.sv
// -----------------------------------------------------------------------------
// arm_multicycle_controller
//
// Control unit for a multicycle ARM core built around one memory port, one ALU
// and one register file. A main FSM walks each instruction through fetch,
// decode, address, memory, execute, writeback and branch phases. The block
// also holds the NZCV flag register and the latched condition result
// (CondExR), and it gates all architectural write enables with that result.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   Cond       : instruction [31:28] condition field
//   Op         : instruction [27:26] major opcode
//   Funct      : instruction [25:20]; [5]=I, [4:1]=cmd, [0]=S/L
//   Rd         : instruction [15:12] destination register
//   ALUFlags   : {N,Z,C,V} produced by the ALU this cycle
//   PCWrite    : PC write enable
//   MemWrite   : data memory write enable
//   RegWrite   : register file write enable
//   IRWrite    : instruction register write enable
//   AdrSrc     : memory address select (0=PC, 1=ALU result register)
//   ALUSrcA    : ALU A select (0=register A, 1=PC)
//   ALUSrcB    : ALU B select
//   ResultSrc  : result bus select
//   ImmSrc     : immediate extension format
//   RegSrc     : register read address selects
//   ALUControl : 00 ADD, 01 SUB, 10 AND, 11 ORR
//   Flags      : registered NZCV
//   State      : current FSM state (debug)
// -----------------------------------------------------------------------------
module arm_multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl,
    output logic [3:0] Flags,
    output logic [3:0] State
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXECR  = 4'd6;
    localparam logic [3:0] S_EXECI  = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    logic [3:0] state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       condex_q, condex_d;

    logic [3:0] cmd;
    logic       s_bit;
    logic       is_cmp;

    // Raw (ungated) controls from the output decoder
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       alu_op;
    logic       ir_w;
    logic       fetch_pc;

    logic [1:0] alu_ctl;
    logic [1:0] flag_w;
    logic [1:0] flag_write;
    logic       dp_reg_w;
    logic       cond_pass;
    logic       n_f, z_f, c_f, v_f;
    logic       regw_eligible;

    assign cmd    = Funct[4:1];
    assign s_bit  = Funct[0];
    assign is_cmp = (cmd == CMD_CMP);

    // ------------------------------------------------------------------
    // State, flag and condition registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_FETCH;
            flags_q  <= 4'b0000;
            condex_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            flags_q  <= flags_d;
            condex_q <= condex_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXECR:  state_d = S_ALUWB;
            S_EXECI:  state_d = S_ALUWB;
            default:  state_d = S_FETCH;   // MEMWB, MEMWR, ALUWB, BRANCH, illegal codes
        endcase
    end

    // ------------------------------------------------------------------
    // Per-state output decode
    // ------------------------------------------------------------------
    always_comb begin
        ir_w      = 1'b0;
        fetch_pc  = 1'b0;
        reg_w     = 1'b0;
        mem_w     = 1'b0;
        branch    = 1'b0;
        alu_op    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        case (state_q)
            S_FETCH: begin
                ir_w      = 1'b1;
                fetch_pc  = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: ALUSrcB = 2'b01;
            S_MEMRD:  AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_w     = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
            end
            S_EXECR: alu_op = 1'b1;
            S_EXECI: begin
                ALUSrcB = 2'b01;
                alu_op  = 1'b1;
            end
            S_ALUWB: reg_w = dp_reg_w;
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU decode. dp_reg_w is the writeback permission for ALUWB: only the
    // four result-producing commands write the register file.
    // ------------------------------------------------------------------
    always_comb begin
        alu_ctl  = 2'b00;
        flag_w   = 2'b00;
        dp_reg_w = 1'b0;
        case (cmd)
            CMD_ADD: begin alu_ctl = 2'b00; flag_w = {2{s_bit}};    dp_reg_w = 1'b1; end
            CMD_SUB: begin alu_ctl = 2'b01; flag_w = {2{s_bit}};    dp_reg_w = 1'b1; end
            CMD_AND: begin alu_ctl = 2'b10; flag_w = {s_bit, 1'b0}; dp_reg_w = 1'b1; end
            CMD_ORR: begin alu_ctl = 2'b11; flag_w = {s_bit, 1'b0}; dp_reg_w = 1'b1; end
            CMD_CMP: begin alu_ctl = 2'b01; flag_w = 2'b11; end
            default: ;
        endcase
    end

    assign ALUControl = alu_op ? alu_ctl : 2'b00;
    assign flag_write = (alu_op ? flag_w : 2'b00) & {2{condex_q}};

    // ------------------------------------------------------------------
    // Condition check against the flag register
    // ------------------------------------------------------------------
    assign {n_f, z_f, c_f, v_f} = flags_q;

    always_comb begin
        cond_pass = 1'b0;
        case (Cond)
            4'b0000: cond_pass = z_f;
            4'b0001: cond_pass = ~z_f;
            4'b0010: cond_pass = c_f;
            4'b0011: cond_pass = ~c_f;
            4'b0100: cond_pass = n_f;
            4'b0101: cond_pass = ~n_f;
            4'b0110: cond_pass = v_f;
            4'b0111: cond_pass = ~v_f;
            4'b1000: cond_pass = c_f & ~z_f;
            4'b1001: cond_pass = ~c_f | z_f;
            4'b1010: cond_pass = (n_f == v_f);
            4'b1011: cond_pass = (n_f != v_f);
            4'b1100: cond_pass = ~z_f & (n_f == v_f);
            4'b1101: cond_pass = z_f | (n_f != v_f);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // The check result is captured only while decoding, so flags written in
    // EXECR/EXECI cannot change the decision for the same instruction's ALUWB.
    assign condex_d = (state_q == S_DECODE) ? cond_pass : condex_q;

    // Flag register halves: [1] covers N,Z and [0] covers C,V.
    for (genvar gi = 0; gi < 2; gi++) begin : g_flag_half
        assign flags_d[2*gi+1 -: 2] = flag_write[gi] ? ALUFlags[2*gi+1 -: 2]
                                                     : flags_q[2*gi+1 -: 2];
    end

    // ------------------------------------------------------------------
    // Gated enables. Every write enable is held low while reset is asserted,
    // which also masks the FETCH enables of the reset state.
    // ------------------------------------------------------------------
    assign regw_eligible = (state_q == S_MEMWB) | ((state_q == S_ALUWB) & ~is_cmp);

    assign IRWrite  = rst & ir_w;
    assign RegWrite = rst & reg_w & condex_q;
    assign MemWrite = rst & mem_w & condex_q;
    assign PCWrite  = rst & (fetch_pc |
                             (condex_q & (branch | (regw_eligible & (Rd == 4'd15)))));

    assign ImmSrc = Op;
    assign RegSrc = {(Op == 2'b01), (Op == 2'b10)};
    assign Flags  = flags_q;
    assign State  = state_q;

endmodule

// File: tb/tb_arm_multicycle_controller.sv
module tb_arm_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] Cond = 4'd0;
    logic [1:0] Op = 2'd0;
    logic [5:0] Funct = 6'd0;
    logic [3:0] Rd = 4'd0;
    logic [3:0] ALUFlags = 4'd0;
    logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
    logic [3:0] Flags, State;

    arm_multicycle_controller dut (
        .clk(clk), .rst(rst), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
        .Flags(Flags), .State(State)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] en;      // {PCWrite, MemWrite, RegWrite, IRWrite}
        logic       adr;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] res;
        logic [1:0] imm;
        logic [1:0] regsrc;
        logic [1:0] aluctl;
        logic [3:0] flags;
    } exp_t;

    exp_t       exp_cur;
    bit         exp_valid = 1'b0;
    logic [3:0] mflags = 4'd0;
    logic       last_pcw, last_memw, last_regw;
    int         n_checks = 0;
    int         n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    endtask

    // Condition table evaluated on {N,Z,C,V}
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cc, v;
        n = f[3]; z = f[2]; cc = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cc;
            4'd3:  return !cc;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cc && !z;
            4'd9:  return !cc || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Single compare process: every negedge while an expectation is live
    always @(negedge clk) begin
        if (exp_valid) begin
            check("state", State, exp_cur.st);
            check("enables", {PCWrite, MemWrite, RegWrite, IRWrite}, exp_cur.en);
            check("path_sel", {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc},
                  {exp_cur.adr, exp_cur.srca, exp_cur.srcb, exp_cur.res});
            check("field_sel", {ImmSrc, RegSrc}, {exp_cur.imm, exp_cur.regsrc});
            check("alu_control", ALUControl, exp_cur.aluctl);
            check("flags", Flags, exp_cur.flags);
            $display("t=%0t state=%0d en=%b flags=%b", $time, State,
                     {PCWrite, MemWrite, RegWrite, IRWrite}, Flags);
        end
        last_pcw  = PCWrite;
        last_memw = MemWrite;
        last_regw = RegWrite;
    end

    // Runs one instruction starting in FETCH (called at posedge+1).
    // abort_at >= 0 pulls reset low at the start of that step instead.
    task automatic run_instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] fn,
                             input logic [3:0] rd, input logic [3:0] af, input int abort_at);
        int         seq[$];
        bit         pass;
        logic [3:0] cmd;
        logic [3:0] st4;
        logic [1:0] ctl, fm;
        bit         dp_wr;
        exp_t       e;
        Cond = c; Op = op; Funct = fn; Rd = rd; ALUFlags = af;
        pass = cond_ok(c, mflags);
        cmd = fn[4:1];
        ctl = 2'b00; fm = 2'b00; dp_wr = 1'b0;
        case (cmd)
            4'b0100: begin ctl = 2'b00; fm = fn[0] ? 2'b11 : 2'b00; dp_wr = 1'b1; end
            4'b0010: begin ctl = 2'b01; fm = fn[0] ? 2'b11 : 2'b00; dp_wr = 1'b1; end
            4'b0000: begin ctl = 2'b10; fm = fn[0] ? 2'b10 : 2'b00; dp_wr = 1'b1; end
            4'b1100: begin ctl = 2'b11; fm = fn[0] ? 2'b10 : 2'b00; dp_wr = 1'b1; end
            4'b1010: begin ctl = 2'b01; fm = 2'b11; end
            default: ;
        endcase
        case (op)
            2'b00:   seq = {0, 1, (fn[5] ? 7 : 6), 8};
            2'b01:   seq = fn[0] ? {0, 1, 2, 3, 4} : {0, 1, 2, 5};
            2'b10:   seq = {0, 1, 9};
            default: seq = {0, 1};
        endcase
        for (int i = 0; i < seq.size(); i++) begin
            st4 = 4'(seq[i]);
            e = '0;
            e.imm = op;
            e.regsrc = {op == 2'b01, op == 2'b10};
            if (i == abort_at) begin
                check("state_before_abort", State, st4);
                rst = 1'b0;
                mflags = 4'd0;
                e.srca = 1'b1; e.srcb = 2'b10; e.res = 2'b10;
                exp_cur = e;
                exp_valid = 1'b1;
                @(posedge clk); #1;
                @(posedge clk); #1;
                check("flags_cleared_by_reset", Flags, 4'b0000);
                rst = 1'b1;
                return;
            end
            e.st = st4;
            e.flags = mflags;
            case (st4)
                4'd0: begin e.en = 4'b1001; e.srca = 1'b1; e.srcb = 2'b10; e.res = 2'b10; end
                4'd1: begin e.srca = 1'b1; e.srcb = 2'b10; e.res = 2'b10; end
                4'd2: e.srcb = 2'b01;
                4'd3: e.adr = 1'b1;
                4'd4: begin e.res = 2'b01; e.en = {pass && rd == 4'd15, 1'b0, pass, 1'b0}; end
                4'd5: begin e.adr = 1'b1; e.en = {1'b0, pass, 2'b00}; end
                4'd6, 4'd7: begin e.srcb = (st4 == 4'd7) ? 2'b01 : 2'b00; e.aluctl = ctl; end
                4'd8: e.en = {pass && cmd != 4'b1010 && rd == 4'd15, 1'b0, pass && dp_wr, 1'b0};
                4'd9: begin e.srcb = 2'b01; e.res = 2'b10; e.en = {pass, 3'b000}; end
                default: ;
            endcase
            exp_cur = e;
            exp_valid = 1'b1;
            @(posedge clk); #1;
            if ((st4 == 4'd6 || st4 == 4'd7) && pass) begin
                if (fm[1]) mflags[3:2] = af[3:2];
                if (fm[0]) mflags[1:0] = af[1:0];
            end
        end
        check("back_to_fetch", State, 4'd0);
    endtask

    initial begin
        exp_cur = '0;
        exp_cur.srca = 1'b1; exp_cur.srcb = 2'b10; exp_cur.res = 2'b10;
        #1 exp_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;

        // ADDS imm, flags <- 0100
        run_instr(4'b1110, 2'b00, 6'b101001, 4'd1, 4'b0100, -1);
        check("adds_flags", Flags, 4'b0100);
        check("adds_regwrite", last_regw, 1'b1);
        // BEQ taken (Z=1)
        run_instr(4'b0000, 2'b10, 6'b100000, 4'd0, 4'b0000, -1);
        check("beq_taken_pcwrite", last_pcw, 1'b1);
        // ADDS clears flags, then BEQ not taken
        run_instr(4'b1110, 2'b00, 6'b101001, 4'd1, 4'b0000, -1);
        run_instr(4'b0000, 2'b10, 6'b100000, 4'd0, 4'b0000, -1);
        check("beq_not_taken_pcwrite", last_pcw, 1'b0);
        // LDR to PC
        run_instr(4'b1110, 2'b01, 6'b011001, 4'd15, 4'b0000, -1);
        check("ldr_pc_regwrite", last_regw, 1'b1);
        check("ldr_pc_pcwrite", last_pcw, 1'b1);
        // STRNE with Z=1 then Z=0
        run_instr(4'b1110, 2'b00, 6'b101001, 4'd1, 4'b0100, -1);
        run_instr(4'b0001, 2'b01, 6'b011000, 4'd2, 4'b0000, -1);
        check("strne_z1_memwrite", last_memw, 1'b0);
        run_instr(4'b1110, 2'b00, 6'b101001, 4'd1, 4'b0000, -1);
        run_instr(4'b0001, 2'b01, 6'b011000, 4'd2, 4'b0000, -1);
        check("strne_z0_memwrite", last_memw, 1'b1);
        // CMP
        run_instr(4'b1110, 2'b00, 6'b010101, 4'd4, 4'b0110, -1);
        check("cmp_flags", Flags, 4'b0110);
        check("cmp_no_regwrite", last_regw, 1'b0);
        // Clear flags, then ANDS: only N,Z load
        run_instr(4'b1110, 2'b00, 6'b101001, 4'd1, 4'b0000, -1);
        run_instr(4'b1110, 2'b00, 6'b000001, 4'd5, 4'b1011, -1);
        check("ands_flags", Flags, 4'b1000);
        // ORR register without S, SUBS failing EQ, unsupported cmd, Op=11
        run_instr(4'b1110, 2'b00, 6'b011000, 4'd6, 4'b0111, -1);
        run_instr(4'b0000, 2'b00, 6'b100101, 4'd7, 4'b1111, -1);
        check("failed_cond_flags_kept", Flags, 4'b1000);
        check("failed_cond_no_regwrite", last_regw, 1'b0);
        run_instr(4'b1110, 2'b00, 6'b000010, 4'd3, 4'b0000, -1);
        check("unsupported_no_regwrite", last_regw, 1'b0);
        run_instr(4'b1110, 2'b11, 6'b000000, 4'd0, 4'b0000, -1);
        // LDR aborted by reset in MEMRD
        run_instr(4'b1110, 2'b01, 6'b011001, 4'd15, 4'b0000, 3);
        #1;
        check("release_irwrite", IRWrite, 1'b1);
        check("release_pcwrite", PCWrite, 1'b1);
        // GE after N=V=1
        run_instr(4'b1110, 2'b00, 6'b101001, 4'd1, 4'b1001, -1);
        check("adds_nv_flags", Flags, 4'b1001);
        run_instr(4'b1010, 2'b00, 6'b001000, 4'd2, 4'b0000, -1);
        check("ge_regwrite", last_regw, 1'b1);

        exp_valid = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
